// File: rtl/pq_op_sequencer.sv
// pq_op_sequencer: command front end for a max-first systolic priority queue.
// Ports: i_cmd_* in, o_pq_*/i_pq_* queue side, o_rsp_* out; PQ_SEQ_STATS_EN adds o_stat_*.
module pq_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ENQ_GAP    = 2,
  parameter int DEQ_GAP    = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [1:0]            o_rsp_status
`ifdef PQ_SEQ_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_stat_enq,
  output logic [CNT_WIDTH-1:0]  o_stat_deq,
  output logic [CNT_WIDTH-1:0]  o_stat_drop
`endif
);

  localparam logic [1:0] OP_PEEK = 2'b00;
  localparam logic [1:0] OP_ENQ  = 2'b01;
  localparam logic [1:0] OP_DEQ  = 2'b10;
  localparam logic [1:0] OP_REP  = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_DFULL = 2'b01;
  localparam logic [1:0] ST_DEMPT = 2'b10;

  localparam int GMAX = (ENQ_GAP > DEQ_GAP) ? ENQ_GAP : DEQ_GAP;
  localparam int GW   = (GMAX < 2) ? 1 : $clog2(GMAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [GW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rsp_q, rsp_d;
  logic [1:0]            sts_q, sts_d;
  logic                  ready;
  logic                  wrt;
  logic                  rd;
  logic                  rsp_vld;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      data_q  <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
      sts_q   <= ST_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      sts_q   <= sts_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;
    sts_d   = sts_q;
    ready   = 1'b0;
    wrt     = 1'b0;
    rd      = 1'b0;
    rsp_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (i_cmd_valid) begin
          op_d    = i_cmd_op;
          data_d  = i_cmd_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Queue status and top are only looked at in this cycle.
        state_d = RESP;
        sts_d   = ST_OK;
        rsp_d   = i_pq_data;
        unique case (op_q)
          OP_ENQ: begin
            rsp_d = data_q;
            if (i_pq_full) begin
              sts_d = ST_DFULL;
            end else begin
              wrt     = 1'b1;
              state_d = SETTLE;
              cnt_d   = GW'(ENQ_GAP - 1);
            end
          end
          OP_DEQ: begin
            if (i_pq_empty) begin
              sts_d = ST_DEMPT;
            end else begin
              rd      = 1'b1;
              state_d = SETTLE;
              cnt_d   = GW'(DEQ_GAP - 1);
            end
          end
          OP_REP: begin
            // Replace on full is fine: one out, one in.
            if (i_pq_empty) begin
              sts_d = ST_DEMPT;
            end else begin
              wrt     = 1'b1;
              rd      = 1'b1;
              state_d = SETTLE;
              cnt_d   = GW'(ENQ_GAP - 1);
            end
          end
          default: begin
          end
        endcase
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - GW'(1);
        end
      end
      RESP: begin
        rsp_vld = 1'b1;
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State resets to IDLE, so ready must be masked while reset is held.
  assign o_cmd_ready  = ready & ~i_RST;
  assign o_pq_wrt     = wrt;
  assign o_pq_read    = rd;
  assign o_pq_data    = data_q;
  assign o_rsp_valid  = rsp_vld;
  assign o_rsp_data   = rsp_q;
  assign o_rsp_status = sts_q;

`ifdef PQ_SEQ_STATS_EN
  logic [CNT_WIDTH-1:0] enq_q;
  logic [CNT_WIDTH-1:0] deq_q;
  logic [CNT_WIDTH-1:0] drop_q;
  logic                 drop;

  assign drop = (state_q == ISSUE) && (sts_d != ST_OK);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      enq_q  <= '0;
      deq_q  <= '0;
      drop_q <= '0;
    end else begin
      if (wrt && (enq_q != '1)) enq_q <= enq_q + 1'b1;
      if (rd && (deq_q != '1)) deq_q <= deq_q + 1'b1;
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  assign o_stat_enq  = enq_q;
  assign o_stat_deq  = deq_q;
  assign o_stat_drop = drop_q;
`endif

endmodule

// File: tb/tb_pq_op_sequencer.sv
// tb_pq_op_sequencer: directed and model-driven checks of pq_op_sequencer.
// Drives the queue side from bench variables and a small max-queue model.
module tb_pq_op_sequencer;

  localparam int CAP = 4;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        pq_wrt;
  logic        pq_read;
  logic [15:0] pq_wdata;
  logic        full_r;
  logic        empty_r;
  logic [15:0] top_r;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
`ifdef PQ_SEQ_STATS_EN
  logic [15:0] st_enq;
  logic [15:0] st_deq;
  logic [15:0] st_drop;
`endif

  int total = 0;
  int bad   = 0;
  int nw    = 0;
  int nr    = 0;
  int enq_t = 0;
  int deq_t = 0;
  int drop_t = 0;
  int q[$];

  pq_op_sequencer dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_op     (cmd_op),
    .i_cmd_data   (cmd_data),
    .o_pq_wrt     (pq_wrt),
    .o_pq_read    (pq_read),
    .o_pq_data    (pq_wdata),
    .i_pq_full    (full_r),
    .i_pq_empty   (empty_r),
    .i_pq_data    (top_r),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_status (rsp_status)
`ifdef PQ_SEQ_STATS_EN
    ,
    .o_stat_enq   (st_enq),
    .o_stat_deq   (st_deq),
    .o_stat_drop  (st_drop)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (pq_wrt) nw++;
    if (pq_read) nr++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency counts the accept edge as the first cycle.
  task automatic cmd(input logic [1:0] op, input logic [15:0] d,
                     input bit ew, input bit er, input logic [15:0] erd,
                     input bit cd, input logic [1:0] est, input int elat);
    int nw0, nr0, n;
    bit rdy_seen;
    @(negedge clk);
    check("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    nw0 = nw;
    nr0 = nr;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("issue_wrt", 32'(pq_wrt), 32'(ew));
    check("issue_read", 32'(pq_read), 32'(er));
    if (ew) check("issue_wdata", 32'(pq_wdata), 32'(d));
    n = 1;
    rdy_seen = 1'b0;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
      if (cmd_ready) rdy_seen = 1'b1;
    end
    check("latency", 32'(n), 32'(elat));
    check("busy_ready", 32'(rdy_seen), 32'd0);
    check("wrt_pulses", 32'(nw - nw0), 32'(ew));
    check("read_pulses", 32'(nr - nr0), 32'(er));
    check("rsp_status", 32'(rsp_status), 32'(est));
    if (cd) check("rsp_data", 32'(rsp_data), 32'(erd));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic int max_idx();
    int m = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] > q[m]) m = i;
    return m;
  endfunction

  initial begin
    logic [15:0] hold_d;
    logic [1:0]  op;
    logic [15:0] d;
    logic [15:0] mx;
    int          mi;
    bit          anyv;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = '0;
    rsp_ready = 1'b0;
    full_r = 1'b0;
    empty_r = 1'b1;
    top_r = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_wrt", 32'(pq_wrt), 32'd0);
    check("rst_read", 32'(pq_read), 32'd0);
    check("rst_wdata", 32'(pq_wdata), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_status", 32'(rsp_status), 32'd0);
    rst = 1'b0;

    cmd(2'b01, 16'h0123, 1, 0, 16'h0123, 1, 2'b00, 4);
    empty_r = 1'b0;
    top_r = 16'h03FF;
    cmd(2'b10, 16'h0000, 0, 1, 16'h03FF, 1, 2'b00, 5);
    top_r = 16'h0200;
    cmd(2'b11, 16'h0010, 1, 1, 16'h0200, 1, 2'b00, 4);
    full_r = 1'b1;
    cmd(2'b01, 16'h0055, 0, 0, 16'h0000, 0, 2'b01, 2);
    full_r = 1'b0;
    empty_r = 1'b1;
    cmd(2'b10, 16'h0000, 0, 0, 16'h0000, 0, 2'b10, 2);
    cmd(2'b11, 16'h0042, 0, 0, 16'h0000, 0, 2'b10, 2);
    empty_r = 1'b0;
    top_r = 16'h0777;
    cmd(2'b00, 16'h0000, 0, 0, 16'h0777, 1, 2'b00, 2);
    full_r = 1'b1;
    top_r = 16'h0500;
    cmd(2'b11, 16'h0099, 1, 1, 16'h0500, 1, 2'b00, 4);
    full_r = 1'b0;

    // Stalled response: outputs hold, no new accept.
    top_r = 16'h0ABC;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    @(negedge clk);
    cmd_op = 2'b01;
    cmd_data = 16'h1111;
    @(negedge clk);
    check("hold_valid0", 32'(rsp_valid), 32'd1);
    hold_d = 16'h0ABC;
    for (int i = 0; i < 10; i++) begin
      top_r = 16'(16'h0F00 + i);
      empty_r = i[0];
      full_r = ~i[0];
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(hold_d));
      check("hold_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    full_r = 1'b0;
    empty_r = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_hold_ready", 32'(cmd_ready), 32'd1);

    // Reset while a dequeue is settling.
    top_r = 16'h0111;
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(cmd_ready), 32'd0);
    check("arst_read", 32'(pq_read), 32'd0);
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_data", 32'(rsp_data), 32'd0);
    check("arst_status", 32'(rsp_status), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    anyv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) anyv = 1'b1;
    end
    check("arst_no_rsp", 32'(anyv), 32'd0);
    check("arst_idle", 32'(cmd_ready), 32'd1);

    // Random ops against a max-queue model.
    for (int k = 0; k < 100; k++) begin
      full_r  = (q.size() == CAP);
      empty_r = (q.size() == 0);
      mi = 0;
      mx = 16'hDEAD;
      if (!empty_r) begin
        mi = max_idx();
        mx = 16'(q[mi]);
      end
      top_r = mx;
      op = 2'($urandom_range(0, 3));
      d  = 16'($urandom_range(0, 65535));
      case (op)
        2'b00: cmd(op, d, 0, 0, mx, 1, 2'b00, 2);
        2'b01: begin
          if (full_r) begin
            cmd(op, d, 0, 0, d, 0, 2'b01, 2);
            drop_t++;
          end else begin
            cmd(op, d, 1, 0, d, 1, 2'b00, 4);
            q.push_back(int'(d));
            enq_t++;
          end
        end
        2'b10: begin
          if (empty_r) begin
            cmd(op, d, 0, 0, mx, 0, 2'b10, 2);
            drop_t++;
          end else begin
            cmd(op, d, 0, 1, mx, 1, 2'b00, 5);
            q.delete(mi);
            deq_t++;
          end
        end
        default: begin
          if (empty_r) begin
            cmd(op, d, 0, 0, mx, 0, 2'b10, 2);
            drop_t++;
          end else begin
            cmd(op, d, 1, 1, mx, 1, 2'b00, 4);
            q.delete(mi);
            q.push_back(int'(d));
            enq_t++;
            deq_t++;
          end
        end
      endcase
    end

`ifdef PQ_SEQ_STATS_EN
    check("stat_enq", 32'(st_enq), 32'(enq_t));
    check("stat_deq", 32'(st_deq), 32'(deq_t));
    check("stat_drop", 32'(st_drop), 32'(drop_t));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
